// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl: valid/ready FIFO controller for an external 2R/1W combinational-read memory macro
module mem_fifo_ctrl #(
    parameter int depth    = 16,
    parameter int addrbits = 4,
    parameter int width    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_inValid,
    output logic                io_inReady,
    input  logic [width-1:0]    io_inData,
    output logic                io_outValid,
    input  logic                io_outReady,
    output logic [width-1:0]    io_outData,
    input  logic [addrbits-1:0] io_peekIdx,
    output logic [width-1:0]    io_peekData,
    output logic                io_peekValid,
    input  logic                io_flush,
    output logic [addrbits:0]   io_count,
    output logic                io_overflow,
    output logic                io_underflow,
    output logic                mem_write_en,
    output logic                mem_write_mask,
    output logic [addrbits-1:0] mem_write_addr,
    output logic [width-1:0]    mem_write_data,
    output logic                mem_read_en0,
    output logic                mem_read_en1,
    output logic [addrbits-1:0] mem_read_addr0,
    output logic [addrbits-1:0] mem_read_addr1,
    input  logic [width-1:0]    mem_read_data0,
    input  logic [width-1:0]    mem_read_data1
);
    localparam logic [addrbits:0] depth_cnt = (addrbits + 1)'(depth);
    logic [addrbits-1:0] wr_ptr, rd_ptr;
    logic [addrbits:0] count;
    logic full, empty, push, pop;
    // Flags, handshakes and memory port drive; read port 0 tracks the head, port 1 the peek slot
    always_comb begin
        full           = count == depth_cnt;
        empty          = count == '0;
        push           = io_inValid & ~full & ~io_flush;
        pop            = ~empty & io_outReady & ~io_flush;
        io_inReady     = ~full;
        io_outValid    = ~empty;
        io_outData     = mem_read_data0;
        io_peekData    = mem_read_data1;
        io_peekValid   = {1'b0, io_peekIdx} < count;
        io_count       = count;
        mem_write_en   = push;
        mem_write_mask = 1'b1;
        mem_write_addr = wr_ptr;
        mem_write_data = io_inData;
        mem_read_en0   = 1'b1;
        mem_read_en1   = 1'b1;
        mem_read_addr0 = rd_ptr;
        mem_read_addr1 = rd_ptr + io_peekIdx;
    end
    // Pointer, occupancy and sticky error state; reset beats flush, flush beats transfers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            io_overflow  <= 1'b0;
            io_underflow <= 1'b0;
        end else begin
            wr_ptr       <= io_flush ? '0 : wr_ptr + addrbits'(push);
            rd_ptr       <= io_flush ? '0 : rd_ptr + addrbits'(pop);
            count        <= io_flush ? '0 : count + (addrbits + 1)'(push) - (addrbits + 1)'(pop);
            io_overflow  <= io_overflow | (io_inValid & full & ~io_flush);
            io_underflow <= io_underflow | (io_outReady & empty & ~io_flush);
        end
    end
endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb_mem_fifo_ctrl: scoreboard bench for mem_fifo_ctrl with a behavioural memory macro
module tb_mem_fifo_ctrl;
    logic       clock = 0, reset = 1;
    logic       io_inValid = 0, io_outReady = 0, io_flush = 0;
    logic [7:0] io_inData = 0;
    logic [3:0] io_peekIdx = 0;
    logic       io_inReady, io_outValid, io_peekValid, io_overflow, io_underflow;
    logic [7:0] io_outData, io_peekData;
    logic [4:0] io_count;
    logic       mem_write_en, mem_write_mask, mem_read_en0, mem_read_en1;
    logic [3:0] mem_write_addr, mem_read_addr0, mem_read_addr1;
    logic [7:0] mem_write_data, mem_read_data0, mem_read_data1;
    logic [7:0] mem [16];
    logic [7:0] exp_q [$];
    int checks = 0, failures = 0, writes = 0, w0 = 0;

    mem_fifo_ctrl dut (
        .clock(clock), .reset(reset),
        .io_inValid(io_inValid), .io_inReady(io_inReady), .io_inData(io_inData),
        .io_outValid(io_outValid), .io_outReady(io_outReady), .io_outData(io_outData),
        .io_peekIdx(io_peekIdx), .io_peekData(io_peekData), .io_peekValid(io_peekValid),
        .io_flush(io_flush), .io_count(io_count),
        .io_overflow(io_overflow), .io_underflow(io_underflow),
        .mem_write_en(mem_write_en), .mem_write_mask(mem_write_mask),
        .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
        .mem_read_en0(mem_read_en0), .mem_read_en1(mem_read_en1),
        .mem_read_addr0(mem_read_addr0), .mem_read_addr1(mem_read_addr1),
        .mem_read_data0(mem_read_data0), .mem_read_data1(mem_read_data1)
    );

    always #5 clock = ~clock;

    // Memory macro: synchronous write, combinational reads
    always @(posedge clock) begin
        if (mem_write_en && mem_write_mask) begin
            mem[mem_write_addr] <= mem_write_data;
            writes <= writes + 1;
        end
    end
    assign mem_read_data0 = mem[mem_read_addr0];
    assign mem_read_data1 = mem[mem_read_addr1];

    // Monitor: every accepted pop must match the oldest expected entry
    always @(negedge clock) begin
        if (!reset && !io_flush && io_outValid && io_outReady) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected actual=%0h required=none", io_outData);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (io_outData !== e) begin
                    failures++;
                    $display("FAIL pop_data actual=%0h required=%0h", io_outData, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input logic [7:0] d);
        io_inValid = 1;
        io_inData = d;
        exp_q.push_back(d);
        cyc();
        io_inValid = 0;
    endtask

    task automatic push_n(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) push_one(base + 8'(i));
    endtask

    task automatic pop_n(input int n);
        io_outReady = 1;
        repeat (n) cyc();
        io_outReady = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        exp_q.delete();
        cyc();
        reset = 0;
    endtask

    initial begin
        io_peekIdx = 5;
        cyc();
        do_reset();
        check("rst_count", io_count, 0);
        check("rst_outValid", io_outValid, 0);
        check("rst_inReady", io_inReady, 1);
        check("rst_peekValid", io_peekValid, 0);
        check("rst_overflow", io_overflow, 0);
        check("rst_underflow", io_underflow, 0);
        check("rst_write_en", mem_write_en, 0);
        check("rst_addr0", mem_read_addr0, 0);
        check("rst_addr1", mem_read_addr1, 5);

        push_one(8'h11); push_one(8'h22); push_one(8'h33);
        check("p3_count", io_count, 3);
        check("p3_outData", io_outData, 8'h11);
        io_peekIdx = 2; #1;
        check("p3_peek2_data", io_peekData, 8'h33);
        check("p3_peek2_valid", io_peekValid, 1);
        io_peekIdx = 3; #1;
        check("p3_peek3_valid", io_peekValid, 0);
        pop_n(3);
        check("p3_drained", io_outValid, 0);

        push_n(16, 8'h00);
        check("full_inReady", io_inReady, 0);
        check("full_count", io_count, 16);
        io_inValid = 1; io_inData = 8'h99; #1;
        check("full_no_write", mem_write_en, 0);
        cyc();
        io_inValid = 0;
        check("full_overflow", io_overflow, 1);
        check("full_count_held", io_count, 16);
        pop_n(16);
        check("full_drained", io_outValid, 0);
        check("full_queue_empty", exp_q.size(), 0);

        do_reset();
        check("rst2_overflow", io_overflow, 0);
        push_n(10, 8'h50);
        pop_n(10);
        push_n(12, 8'hA0);
        check("wrap_count", io_count, 12);
        check("wrap_head_addr", mem_read_addr0, 10);
        io_inValid = 1; io_inData = 8'hFF; #1;
        check("wrap_wr_ptr", mem_write_addr, 6);
        io_inValid = 0;
        io_peekIdx = 11; #1;
        check("wrap_peek_addr", mem_read_addr1, 5);
        check("wrap_peek_data", io_peekData, 8'hAB);
        check("wrap_peek_valid", io_peekValid, 1);
        io_peekIdx = 12; #1;
        check("wrap_peek12_valid", io_peekValid, 0);
        pop_n(12);
        check("wrap_drained", exp_q.size(), 0);

        push_n(5, 8'h30);
        io_outReady = 1;
        for (int i = 0; i < 20; i++) begin
            io_inValid = 1;
            io_inData = 8'h40 + 8'(i);
            exp_q.push_back(io_inData);
            cyc();
            check("pp_count", io_count, 5);
        end
        io_inValid = 0;
        io_outReady = 0;
        pop_n(5);
        check("pp_drained", exp_q.size(), 0);

        io_outReady = 1; #1;
        check("uf_no_write", mem_write_en, 0);
        cyc();
        io_outReady = 0;
        check("uf_underflow", io_underflow, 1);
        check("uf_count", io_count, 0);

        push_n(7, 8'h70);
        check("fl_count7", io_count, 7);
        io_inValid = 1; io_inData = 8'hEE; io_outReady = 1; io_flush = 1; #1;
        check("fl_no_write_en", mem_write_en, 0);
        w0 = writes;
        cyc();
        io_inValid = 0; io_outReady = 0; io_flush = 0;
        exp_q.delete();
        check("fl_writes", writes - w0, 0);
        check("fl_count", io_count, 0);
        check("fl_outValid", io_outValid, 0);
        check("fl_overflow", io_overflow, 0);
        check("fl_underflow", io_underflow, 1);

        push_n(9, 8'h90);
        check("mid_count9", io_count, 9);
        io_inValid = 1; io_inData = 8'h99; reset = 1;
        cyc();
        reset = 0; io_inValid = 0;
        exp_q.delete();
        check("mid_rst_count", io_count, 0);
        check("mid_rst_outValid", io_outValid, 0);
        check("mid_rst_underflow", io_underflow, 0);
        check("mid_rst_addr0", mem_read_addr0, 0);

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
